// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin scheduler sharing one UART transmitter among N requesters
// Packet lock keeps the grant on one requester until it sends a byte marked last.
module uart_tx_arbiter #(
  parameter int N           = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [8*N-1:0]       req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 locked,
  output logic                 err_timeout
);
  localparam int IDW = $clog2(N);
  localparam int CW  = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {ARB, ISSUE, WAIT_ACK, WAIT_DONE} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gid_q, gid_d;
  logic           locked_q, locked_d;
  logic           last_q, last_d;
  logic [7:0]     data_q, data_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           start_q, start_d;
  logic           err_q, err_d;

  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] gid_next;
  logic [N-1:0]   ready;
  int             idx;

  assign gid_next = (gid_q == IDW'(N - 1)) ? '0 : gid_q + IDW'(1);

  // Scan from lowest to highest priority so the last hit is the ptr-nearest requester.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    if (locked_q) begin
      win_found = req_valid[gid_q];
      win_id    = gid_q;
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = (int'(ptr_q) + k) % N;
        if (req_valid[idx]) begin
          win_found = 1'b1;
          win_id    = IDW'(idx);
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gid_d    = gid_q;
    locked_d = locked_q;
    last_d   = last_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    start_d  = 1'b0;
    err_d    = err_q;
    ready    = '0;
    case (state_q)
      ARB: begin
        if (win_found) begin
          ready[win_id] = 1'b1;
          data_d        = req_data[int'(win_id)*8 +: 8];
          last_d        = req_last[win_id];
          gid_d         = win_id;
          start_d       = 1'b1;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          err_d    = 1'b1;
          locked_d = 1'b0;
          ptr_d    = gid_next;
          state_d  = ARB;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = ARB;
          if (last_q) begin
            locked_d = 1'b0;
            ptr_d    = gid_next;
          end else begin
            locked_d = 1'b1;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB;
      ptr_q    <= '0;
      gid_q    <= '0;
      locked_q <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= 8'h00;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gid_q    <= gid_d;
      locked_q <= locked_d;
      last_q   <= last_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      err_q    <= err_d;
    end
  end

  // The handshake is combinational; hold it off while rst is asserted.
  assign req_ready   = rst ? '0 : ready;
  assign tx_start    = start_q;
  assign tx_data     = data_q;
  assign grant_id    = gid_q;
  assign locked      = locked_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
// Transaction-level reference model plus per-scenario directed and randomized tests.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int AT = 15;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy = 1'b0;
  logic [1:0]     grant_id;
  logic           locked;
  logic           err_timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(N), .ACK_TIMEOUT(AT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .locked(locked), .err_timeout(err_timeout)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] rq_data [N][64];
  logic       rq_last [N][64];
  int         rq_n [N];
  int         rq_h [N];
  logic [N-1:0] pause = '0;
  logic [N-1:0] hs_vec = '0;

  int busy_cnt = 0;
  int frame_len = 20;
  bit rand_len = 1'b0;
  bit xmit_en = 1'b1;

  int         m_phase = 0, m_k = 0, m_ptr = 0, m_owner = 0, m_gid = 0;
  bit         m_locked = 1'b0, m_err = 1'b0, m_last = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         acc_id[$];
  int         acc_dat[$];
  int         start_cnt = 0;
  bit         stall_watch = 1'b0;
  int         stall_ready0 = 0;

  // Transmitter: busy for a frame's worth of cycles after each start pulse
  always @(negedge clk) begin
    if (rst) busy_cnt = 0;
    else if (tx_start && xmit_en) busy_cnt = rand_len ? int'($urandom_range(2, 7)) : frame_len;
    else if (busy_cnt > 0) busy_cnt--;
    tx_busy = (busy_cnt > 0);
  end

  function automatic logic [N-1:0] exp_ready(input logic [N-1:0] v);
    logic [N-1:0] r;
    bit found;
    r = '0;
    found = 1'b0;
    if (m_locked) begin
      if (v[m_owner]) r[m_owner] = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!found && v[(m_ptr + k) % N]) begin
          r[(m_ptr + k) % N] = 1'b1;
          found = 1'b1;
        end
      end
    end
    return r;
  endfunction

  // Reference model: follows each transaction as accept -> start -> ack -> done/timeout
  always @(negedge clk) begin : monitor
    logic [N-1:0] er;
    int id;
    #2;
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_gid = 0; m_locked = 1'b0; m_err = 1'b0; m_owner = 0;
      hs_vec = '0;
    end else begin
      er = (m_phase == 0) ? exp_ready(req_valid) : '0;
      tests_run++;
      if (req_ready !== er) begin
        tests_failed++;
        $display("FAIL mon_req_ready: got %b expected %b (t=%0t)", req_ready, er, $time);
      end
      tests_run++;
      if (tx_start !== (m_phase == 1)) begin
        tests_failed++;
        $display("FAIL mon_tx_start: got %b expected %b (t=%0t)", tx_start, (m_phase == 1), $time);
      end
      tests_run++;
      if (locked !== m_locked) begin
        tests_failed++;
        $display("FAIL mon_locked: got %b expected %b (t=%0t)", locked, m_locked, $time);
      end
      tests_run++;
      if (err_timeout !== m_err) begin
        tests_failed++;
        $display("FAIL mon_err_timeout: got %b expected %b (t=%0t)", err_timeout, m_err, $time);
      end
      tests_run++;
      if (grant_id !== 2'(m_gid)) begin
        tests_failed++;
        $display("FAIL mon_grant_id: got %0d expected %0d (t=%0t)", grant_id, m_gid, $time);
      end
      if (m_phase == 1 || m_phase == 3) begin
        tests_run++;
        if (tx_data !== m_data) begin
          tests_failed++;
          $display("FAIL mon_tx_data: got %h expected %h (t=%0t)", tx_data, m_data, $time);
        end
      end
      hs_vec = req_valid & req_ready;
      if (stall_watch && req_ready[0]) stall_ready0++;
      if (tx_start) start_cnt++;
      case (m_phase)
        0: if (hs_vec != '0) begin
          id = 0;
          for (int i = N - 1; i >= 0; i--) if (hs_vec[i]) id = i;
          m_gid = id;
          m_data = req_data[8*id +: 8];
          m_last = req_last[id];
          acc_id.push_back(id);
          acc_dat.push_back(int'(m_data));
          m_phase = 1;
        end
        1: begin m_phase = 2; m_k = 0; end
        2: begin
          m_k++;
          if (tx_busy) m_phase = 3;
          else if (m_k == AT) begin
            m_err = 1'b1; m_locked = 1'b0; m_ptr = (m_gid + 1) % N; m_phase = 0;
          end
        end
        3: if (!tx_busy) begin
          if (m_last) begin m_locked = 1'b0; m_ptr = (m_gid + 1) % N; end
          else begin m_locked = 1'b1; m_owner = m_gid; end
          m_phase = 0;
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (hs_vec[i]) rq_h[i]++;
      req_valid[i] = !pause[i] && (rq_h[i] < rq_n[i]);
      req_data[8*i +: 8] = (rq_h[i] < 64) ? rq_data[i][rq_h[i]] : 8'h00;
      req_last[i] = (rq_h[i] < 64) ? rq_last[i][rq_h[i]] : 1'b0;
    end
    #3;
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l);
    rq_data[i][rq_n[i]] = d;
    rq_last[i][rq_n[i]] = l;
    rq_n[i]++;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < N; i++) begin rq_n[i] = 0; rq_h[i] = 0; end
    pause = '0; req_valid = '0; req_data = '0; req_last = '0;
    acc_id.delete(); acc_dat.delete(); start_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_stim();
    xmit_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #3;
  endtask

  task automatic run_idle(input int budget, input string name);
    int n;
    bit pend;
    n = 0;
    pend = 1'b1;
    while (pend && n < budget) begin
      step();
      n++;
      pend = (m_phase != 0) || tx_busy;
      for (int i = 0; i < N; i++) if (rq_h[i] < rq_n[i]) pend = 1'b1;
    end
    tests_run++;
    if (pend) begin
      tests_failed++;
      $display("FAIL %s_drain: still busy after %0d cycles, required idle", name, budget);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '1;
    req_data = 32'hDEADBEEF;
    #3;
    tests_run += 6;
    if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_req_ready: got %b required 0000", req_ready); end
    if (tx_start !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_start: got %b required 0", tx_start); end
    if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_data: got %h required 00", tx_data); end
    if (grant_id !== 2'd0) begin tests_failed++; $display("FAIL reset_grant_id: got %0d required 0", grant_id); end
    if (locked !== 1'b0) begin tests_failed++; $display("FAIL reset_locked: got %b required 0", locked); end
    if (err_timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b required 0", err_timeout); end
    do_reset();
  endtask

  task automatic test_single();
    int n;
    do_reset();
    rand_len = 1'b0;
    frame_len = 20;
    push(2, 8'hA5, 1'b1);
    n = 0;
    step();
    while (req_ready == '0 && n < 10) begin step(); n++; end
    tests_run++;
    if (req_ready !== 4'b0100) begin tests_failed++; $display("FAIL single_ready: got %b required 0100", req_ready); end
    step();
    tests_run += 3;
    if (tx_start !== 1'b1) begin tests_failed++; $display("FAIL single_start: got %b required 1", tx_start); end
    if (tx_data !== 8'hA5) begin tests_failed++; $display("FAIL single_data: got %h required a5", tx_data); end
    if (grant_id !== 2'd2) begin tests_failed++; $display("FAIL single_gid: got %0d required 2", grant_id); end
    run_idle(100, "single");
    push(0, 8'h11, 1'b1);
    push(3, 8'h33, 1'b1);
    run_idle(100, "single_ptr");
    tests_run++;
    if (acc_id.size() != 3 || acc_id[1] != 3 || acc_id[2] != 0) begin
      tests_failed++;
      $display("FAIL single_ptr_order: got size %0d, required order 2,3,0", acc_id.size());
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] d [12];
    do_reset();
    rand_len = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) begin
        d[r*N + i] = 8'($urandom);
        push(i, d[r*N + i], 1'b1);
      end
    run_idle(1000, "rr");
    tests_run++;
    if (acc_id.size() != 12) begin
      tests_failed++;
      $display("FAIL rr_count: got %0d accepts required 12", acc_id.size());
    end else begin
      for (int k = 0; k < 12; k++) begin
        tests_run += 2;
        if (acc_id[k] != k % N) begin tests_failed++; $display("FAIL rr_order[%0d]: got %0d required %0d", k, acc_id[k], k % N); end
        if (acc_dat[k] != int'(d[(k % N)*3 + 0] * 0) + int'(d[(k / N)*N + (k % N)])) begin
          tests_failed++; $display("FAIL rr_data[%0d]: got %h required %h", k, acc_dat[k], d[(k / N)*N + (k % N)]);
        end
      end
    end
    tests_run++;
    if (start_cnt != 12) begin tests_failed++; $display("FAIL rr_starts: got %0d required 12", start_cnt); end
  endtask

  task automatic test_packet_lock();
    int n, prev;
    int exp_ord [5];
    exp_ord = '{1, 1, 1, 0, 0};
    do_reset();
    rand_len = 1'b1;
    push(1, 8'h21, 1'b0); push(1, 8'h22, 1'b0); push(1, 8'h23, 1'b1);
    push(0, 8'h01, 1'b1); push(0, 8'h02, 1'b1);
    pause[0] = 1'b1;
    n = 0;
    while (acc_id.size() < 1 && n < 20) begin step(); n++; end
    pause[0] = 1'b0;
    prev = acc_id.size();
    n = 0;
    while (acc_id.size() < 3 && n < 200) begin
      step();
      n++;
      if (acc_id.size() != prev) begin
        prev = acc_id.size();
        tests_run++;
        if (locked !== 1'b1) begin tests_failed++; $display("FAIL lock_held[%0d]: got %b required 1", prev, locked); end
      end
    end
    run_idle(300, "lock");
    tests_run++;
    if (acc_id.size() != 5) begin
      tests_failed++;
      $display("FAIL lock_count: got %0d required 5", acc_id.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        tests_run++;
        if (acc_id[k] != exp_ord[k]) begin tests_failed++; $display("FAIL lock_order[%0d]: got %0d required %0d", k, acc_id[k], exp_ord[k]); end
      end
    end
    tests_run++;
    if (locked !== 1'b0) begin tests_failed++; $display("FAIL lock_release: got %b required 0", locked); end
  endtask

  task automatic test_lock_stall();
    int n;
    do_reset();
    rand_len = 1'b1;
    push(3, 8'h31, 1'b0); push(3, 8'h32, 1'b1); push(0, 8'h05, 1'b1);
    pause[0] = 1'b1;
    n = 0;
    while (acc_id.size() < 1 && n < 20) begin step(); n++; end
    pause[3] = 1'b1;
    pause[0] = 1'b0;
    stall_ready0 = 0;
    stall_watch = 1'b1;
    repeat (50) step();
    tests_run++;
    if (locked !== 1'b1) begin tests_failed++; $display("FAIL stall_locked: got %b required 1", locked); end
    pause[3] = 1'b0;
    n = 0;
    while (acc_id.size() < 2 && n < 20) begin step(); n++; end
    stall_watch = 1'b0;
    tests_run++;
    if (stall_ready0 != 0) begin tests_failed++; $display("FAIL stall_ready0: got %0d grants to 0 during lock, required 0", stall_ready0); end
    run_idle(200, "stall");
    tests_run++;
    if (acc_id.size() != 3 || acc_id[0] != 3 || acc_id[1] != 3 || acc_id[2] != 0) begin
      tests_failed++;
      $display("FAIL stall_order: got %0d accepts, required order 3,3,0", acc_id.size());
    end
  endtask

  task automatic test_timeout();
    int n;
    int exp_ord [4];
    exp_ord = '{1, 2, 0, 1};
    do_reset();
    rand_len = 1'b1;
    xmit_en = 1'b0;
    push(1, 8'h41, 1'b0);
    push(2, 8'h42, 1'b1);
    n = 0;
    while (acc_id.size() < 1 && n < 20) begin step(); n++; end
    push(1, 8'h43, 1'b1);
    push(0, 8'h44, 1'b1);
    n = 0;
    while (err_timeout !== 1'b1 && n < 40) begin step(); n++; end
    xmit_en = 1'b1;
    tests_run += 2;
    if (n != AT + 2) begin tests_failed++; $display("FAIL timeout_latency: got %0d cycles required %0d", n, AT + 2); end
    if (locked !== 1'b0) begin tests_failed++; $display("FAIL timeout_unlock: got %b required 0", locked); end
    run_idle(300, "timeout");
    tests_run++;
    if (acc_id.size() != 4) begin
      tests_failed++;
      $display("FAIL timeout_count: got %0d required 4", acc_id.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests_run++;
        if (acc_id[k] != exp_ord[k]) begin tests_failed++; $display("FAIL timeout_order[%0d]: got %0d required %0d", k, acc_id[k], exp_ord[k]); end
      end
    end
    tests_run++;
    if (err_timeout !== 1'b1) begin tests_failed++; $display("FAIL timeout_sticky: got %b required 1", err_timeout); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    rand_len = 1'b0;
    frame_len = 30;
    push(1, 8'h5C, 1'b0);
    n = 0;
    while (m_phase != 3 && n < 40) begin step(); n++; end
    repeat (3) step();
    rst = 1'b1;
    #1;
    tests_run += 6;
    if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL mid_tx_data: got %h required 00", tx_data); end
    if (grant_id !== 2'd0) begin tests_failed++; $display("FAIL mid_grant_id: got %0d required 0", grant_id); end
    if (locked !== 1'b0) begin tests_failed++; $display("FAIL mid_locked: got %b required 0", locked); end
    if (tx_start !== 1'b0) begin tests_failed++; $display("FAIL mid_tx_start: got %b required 0", tx_start); end
    if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL mid_req_ready: got %b required 0000", req_ready); end
    if (err_timeout !== 1'b0) begin tests_failed++; $display("FAIL mid_err: got %b required 0", err_timeout); end
    repeat (2) @(negedge clk);
    clear_stim();
    rst = 1'b0;
    #3;
    push(3, 8'h73, 1'b1);
    push(0, 8'h70, 1'b1);
    n = 0;
    while (acc_id.size() < 1 && n < 20) begin step(); n++; end
    tests_run++;
    if (acc_id.size() < 1 || acc_id[0] != 0) begin
      tests_failed++;
      $display("FAIL mid_next_accept: got %0d accepts / first id %0d, required first id 0", acc_id.size(), (acc_id.size() > 0) ? acc_id[0] : -1);
    end
    run_idle(200, "mid");
  endtask

  task automatic test_random();
    int total;
    do_reset();
    rand_len = 1'b1;
    total = 0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int i;
        i = int'($urandom_range(0, N - 1));
        if (rq_n[i] < 60) begin
          push(i, 8'($urandom), 1'($urandom_range(0, 2) != 0));
          total++;
        end
      end
      if ($urandom_range(0, 7) == 0) pause[$urandom_range(0, N - 1)] ^= 1'b1;
      step();
    end
    for (int i = 0; i < N; i++) if (rq_n[i] > 0) rq_last[i][rq_n[i] - 1] = 1'b1;
    pause = '0;
    run_idle(3000, "random");
    tests_run += 2;
    if (acc_id.size() != total) begin tests_failed++; $display("FAIL random_count: got %0d accepts required %0d", acc_id.size(), total); end
    if (start_cnt != acc_id.size()) begin tests_failed++; $display("FAIL random_starts: got %0d starts required %0d", start_cnt, acc_id.size()); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin rq_n[i] = 0; rq_h[i] = 0; end
    test_reset();
    test_single();
    test_round_robin();
    test_packet_lock();
    test_lock_stall();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
